button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
Conditions the raw push buttons (centre/up/down/left/right) before they reach game_console. Per button: 2-flop synchroniser, debouncer, and one-cycle press/release pulses. game_status uses the press pulse for start; the second-game engine uses the debounced levels for movement. Sits between the board pins and game_console, in the same clock domain.

Parameters:
NUM_BUTTONS, 5, number of independent button channels.
DEBOUNCE_CYCLES, 500000, consecutive cycles a synchronised input must disagree with the stable state before the stable state flips (5 ms at 100 MHz); must be >= 1.
REPEAT_DELAY_CYCLES, 50000000, cycles from the initial press pulse to the first auto-repeat pulse (used only with BUTTON_AUTO_REPEAT_EN).
REPEAT_RATE_CYCLES, 10000000, cycles between subsequent auto-repeat pulses (used only with BUTTON_AUTO_REPEAT_EN).

Ports:
clk  input  1  system clock
rst_n  input  1  reset; synchronous, active-low
i_buttons  input  NUM_BUTTONS  raw button pins; asynchronous, active-high, may bounce
o_level  output  NUM_BUTTONS  debounced stable level per button
o_press  output  NUM_BUTTONS  one-cycle pulse per press (and per repeat when enabled)
o_release  output  NUM_BUTTONS  one-cycle pulse on debounced falling edge
o_any_press  output  1  registered OR of o_press, aligned with o_press

Behaviour:
- Reset: rst_n sampled low at a clk edge clears every synchroniser flop, stable level, counter and repeat state. All outputs are 0 from the following cycle. Reset mid-debounce or mid-repeat discards the progress; no pulse is emitted for it.
- Synchroniser: sync1 <= i_buttons[k]; sync2 <= sync1. Only sync2 is used downstream.
- Debounce counter, per button, width $clog2(DEBOUNCE_CYCLES+1):
  - sync2 == stable: counter cleared.
  - sync2 != stable: counter increments.
  - Increment that reaches DEBOUNCE_CYCLES: stable <= sync2 and counter cleared in the same edge.
  - Any agreement cycle restarts the count, so bounces shorter than DEBOUNCE_CYCLES are rejected.
- Latency: raw input first sampled high at edge 0 and held. o_level goes high after edge DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 edges total. The same figure applies to release.
- Pulses:
  - o_press[k] is high exactly in the first cycle o_level[k] reads 1.
  - o_release[k] is high exactly in the first cycle o_level[k] reads 0.
  - All outputs are registered.
- Channels are fully independent. Simultaneous presses on several buttons produce simultaneous pulses. o_any_press is 1 in that cycle.
- Button held through reset release: stable restarts at 0, so a press pulse is emitted DEBOUNCE_CYCLES+2 edges after reset deasserts. This is the intended behaviour.
- Per-button repeat FSM (active only with the macro):
  - IDLE: level 0. On press pulse -> DELAY, repeat counter cleared.
  - DELAY: counter counts each cycle. At REPEAT_DELAY_CYCLES after the press pulse: emit an o_press pulse, -> REPEAT, counter cleared.
  - REPEAT: pulse every REPEAT_RATE_CYCLES.
  - Debounced release from any state -> IDLE in the same edge. The release pulse is emitted; no press pulse is emitted in that cycle.
  - Counter width is $clog2(max(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES)+1). It never wraps: it is cleared on each pulse.

Optional Feature:
BUTTON_AUTO_REPEAT_EN
- Defined: the repeat FSM is compiled in. Holding a button generates additional o_press (and o_any_press) pulses per the Behaviour section.
- Undefined: the FSM and its counters are absent. o_press pulses once per debounced rising edge only. o_level and o_release are unchanged.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=20, REPEAT_RATE_CYCLES=8, NUM_BUTTONS=5.
- Clean press: i_buttons=5'b00001 held from edge 0 -> o_level[0]=1 and o_press[0]=1 after edge 5. o_press[0]=0 after edge 6. Other bits stay 0.
- Bounce rejection: bit 2 toggles 1,1,1,0 repeatedly (never 4 high in a row after sync) -> o_level[2], o_press[2] and o_release[2] stay 0 throughout.
- Release: after a debounced hold, drop bit 0 at edge 100 -> o_level[0]=0 and o_release[0]=1 after edge 105, for one cycle only.
- Simultaneous: bits 1 and 3 rise at the same edge -> o_press=5'b01010 in one cycle, o_any_press=1 in that same cycle.
- Reset mid-operation: rst_n=0 at edge 3 of a debounce in progress -> all outputs 0, no pulse. Holding the button after rst_n=1 -> press pulse 6 edges after reset release.
- Auto-repeat (macro defined): hold bit 4 for 60 cycles -> o_press[4] pulses at press+0, +20, +28, +36, +44, +52. Release -> no further pulses. Macro undefined: a single pulse only.

Source files
------------

// File: rtl/button_conditioner.sv
// Per-button 2-flop synchroniser, debouncer and registered press/release pulses.
// Optional hold-to-repeat press pulses are compiled in with BUTTON_AUTO_REPEAT_EN.
module button_conditioner #(
  parameter int NUM_BUTTONS         = 5,
  parameter int DEBOUNCE_CYCLES     = 500000,
  parameter int REPEAT_DELAY_CYCLES = 50000000,
  parameter int REPEAT_RATE_CYCLES  = 10000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_BUTTONS-1:0] i_buttons,
  output logic [NUM_BUTTONS-1:0] o_level,
  output logic [NUM_BUTTONS-1:0] o_press,
  output logic [NUM_BUTTONS-1:0] o_release,
  output logic                   o_any_press
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY_CYCLES < 1 || REPEAT_RATE_CYCLES < 1) begin : g_bad_cfg
    $error("button_conditioner: cycle counts must be >= 1");
  end

  logic [NUM_BUTTONS-1:0] sync1_q, sync2_q, stable_q, stable_d;
  logic [NUM_BUTTONS-1:0] rise, fall, rpt_pulse, press_d;
  logic [DW-1:0]          db_cnt_q [NUM_BUTTONS];
  logic [DW-1:0]          db_cnt_d [NUM_BUTTONS];

  // The stable level flips on the edge where the disagreement count would reach DEBOUNCE_CYCLES.
  always_comb begin
    stable_d = stable_q;
    rise     = '0;
    fall     = '0;
    for (int k = 0; k < NUM_BUTTONS; k++) begin
      db_cnt_d[k] = '0;
      if (sync2_q[k] != stable_q[k]) begin
        if (db_cnt_q[k] == DB_LAST) begin
          stable_d[k] = sync2_q[k];
          rise[k]     = sync2_q[k];
          fall[k]     = ~sync2_q[k];
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + 1'b1;
        end
      end
    end
  end

  assign press_d = rise | rpt_pulse;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      stable_q    <= '0;
      o_press     <= '0;
      o_release   <= '0;
      o_any_press <= 1'b0;
      for (int k = 0; k < NUM_BUTTONS; k++) db_cnt_q[k] <= '0;
    end else begin
      sync1_q     <= i_buttons;
      sync2_q     <= sync1_q;
      stable_q    <= stable_d;
      o_press     <= press_d;
      o_release   <= fall;
      o_any_press <= |press_d;
      for (int k = 0; k < NUM_BUTTONS; k++) db_cnt_q[k] <= db_cnt_d[k];
    end
  end

  assign o_level = stable_q;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                           REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int RW = $clog2(RPT_MAX + 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE_CYCLES - 1);

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  // rpt_state_q is the per-button FSM state, visible hierarchically for checkers.
  rpt_state_t    rpt_state_q [NUM_BUTTONS];
  rpt_state_t    rpt_state_d [NUM_BUTTONS];
  logic [RW-1:0] rpt_cnt_q   [NUM_BUTTONS];
  logic [RW-1:0] rpt_cnt_d   [NUM_BUTTONS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_BUTTONS; k++) begin
        rpt_state_q[k] <= RPT_IDLE;
        rpt_cnt_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_BUTTONS; k++) begin
        rpt_state_q[k] <= rpt_state_d[k];
        rpt_cnt_q[k]   <= rpt_cnt_d[k];
      end
    end
  end

  // A debounced release always wins over a repeat pulse due in the same cycle.
  always_comb begin
    rpt_pulse = '0;
    for (int k = 0; k < NUM_BUTTONS; k++) begin
      rpt_state_d[k] = rpt_state_q[k];
      rpt_cnt_d[k]   = rpt_cnt_q[k];
      case (rpt_state_q[k])
        RPT_IDLE: begin
          if (rise[k]) begin
            rpt_state_d[k] = RPT_DELAY;
            rpt_cnt_d[k]   = '0;
          end
        end
        RPT_DELAY, RPT_REPEAT: begin
          if (fall[k]) begin
            rpt_state_d[k] = RPT_IDLE;
            rpt_cnt_d[k]   = '0;
          end else if ((rpt_state_q[k] == RPT_DELAY  && rpt_cnt_q[k] == DELAY_LAST) ||
                       (rpt_state_q[k] == RPT_REPEAT && rpt_cnt_q[k] == RATE_LAST)) begin
            rpt_pulse[k]   = 1'b1;
            rpt_state_d[k] = RPT_REPEAT;
            rpt_cnt_d[k]   = '0;
          end else begin
            rpt_cnt_d[k]   = rpt_cnt_q[k] + 1'b1;
          end
        end
        default: begin
          rpt_state_d[k] = RPT_IDLE;
          rpt_cnt_d[k]   = '0;
        end
      endcase
    end
  end
`else
  assign rpt_pulse = '0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/repeat settings.
// Expected repeat pulses depend on whether BUTTON_AUTO_REPEAT_EN is defined.
module tb_button_conditioner;

  localparam int N  = 5;
  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RR = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] i_buttons = '0;
  logic [N-1:0] o_level, o_press, o_release;
  logic         o_any_press;

  int checks = 0;
  int errors = 0;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam bit RPT_EN = 1'b1;
`else
  localparam bit RPT_EN = 1'b0;
`endif

  button_conditioner #(
    .NUM_BUTTONS(N),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY_CYCLES(RD),
    .REPEAT_RATE_CYCLES(RR)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_buttons(i_buttons),
    .o_level(o_level),
    .o_press(o_press),
    .o_release(o_release),
    .o_any_press(o_any_press)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, leaving the bench 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_buttons = 5'b11111;
    step(3);
    checks++;
    if ({o_level, o_press, o_release, o_any_press} !== 16'h0) begin
      errors++;
      $display("FAIL reset_hold got lvl=%b prs=%b rel=%b any=%b exp all 0",
               o_level, o_press, o_release, o_any_press);
    end
    i_buttons = '0;
    step(2);
    rst_n = 1'b1;
    step(3);
    checks++;
    if ({o_level, o_press, o_release, o_any_press} !== 16'h0) begin
      errors++;
      $display("FAIL reset_after got lvl=%b prs=%b rel=%b any=%b exp all 0",
               o_level, o_press, o_release, o_any_press);
    end
  endtask

  task automatic test_clean_press();
    i_buttons = 5'b00001;
    step(5);
    checks++;
    if (o_level !== 5'b00000 || o_press !== 5'b00000) begin
      errors++;
      $display("FAIL press_early got lvl=%b prs=%b exp 00000 00000", o_level, o_press);
    end
    step(1);
    checks++;
    if (o_level !== 5'b00001 || o_press !== 5'b00001 || o_any_press !== 1'b1 ||
        o_release !== 5'b00000) begin
      errors++;
      $display("FAIL press_edge got lvl=%b prs=%b any=%b rel=%b exp 00001 00001 1 00000",
               o_level, o_press, o_any_press, o_release);
    end
    step(1);
    checks++;
    if (o_level !== 5'b00001 || o_press !== 5'b00000 || o_any_press !== 1'b0) begin
      errors++;
      $display("FAIL press_once got lvl=%b prs=%b any=%b exp 00001 00000 0",
               o_level, o_press, o_any_press);
    end
  endtask

  task automatic test_release();
    step(10);
    i_buttons = 5'b00000;
    step(5);
    checks++;
    if (o_level !== 5'b00001 || o_release !== 5'b00000) begin
      errors++;
      $display("FAIL release_early got lvl=%b rel=%b exp 00001 00000", o_level, o_release);
    end
    step(1);
    checks++;
    if (o_level !== 5'b00000 || o_release !== 5'b00001 || o_press !== 5'b00000) begin
      errors++;
      $display("FAIL release_edge got lvl=%b rel=%b prs=%b exp 00000 00001 00000",
               o_level, o_release, o_press);
    end
    step(1);
    checks++;
    if (o_release !== 5'b00000) begin
      errors++;
      $display("FAIL release_once got rel=%b exp 00000", o_release);
    end
  endtask

  task automatic test_bounce();
    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < 4; j++) begin
        i_buttons[2] = (j != 3);
        step(1);
        checks++;
        if ({o_level[2], o_press[2], o_release[2]} !== 3'b000) begin
          errors++;
          $display("FAIL bounce r=%0d j=%0d got lvl/prs/rel=%b exp 000", r, j,
                   {o_level[2], o_press[2], o_release[2]});
        end
      end
    end
    i_buttons = '0;
    step(8);
    checks++;
    if (o_level !== 5'b00000 || o_release !== 5'b00000) begin
      errors++;
      $display("FAIL bounce_settle got lvl=%b rel=%b exp 00000 00000", o_level, o_release);
    end
  endtask

  task automatic test_simultaneous();
    i_buttons = 5'b01010;
    step(5);
    checks++;
    if (o_press !== 5'b00000 || o_any_press !== 1'b0) begin
      errors++;
      $display("FAIL simul_early got prs=%b any=%b exp 00000 0", o_press, o_any_press);
    end
    step(1);
    checks++;
    if (o_press !== 5'b01010 || o_any_press !== 1'b1 || o_level !== 5'b01010) begin
      errors++;
      $display("FAIL simul_edge got prs=%b any=%b lvl=%b exp 01010 1 01010",
               o_press, o_any_press, o_level);
    end
    step(1);
    checks++;
    if (o_press !== 5'b00000 || o_any_press !== 1'b0) begin
      errors++;
      $display("FAIL simul_once got prs=%b any=%b exp 00000 0", o_press, o_any_press);
    end
    i_buttons = '0;
    step(5);
    checks++;
    if (o_release !== 5'b00000 || o_level !== 5'b01010) begin
      errors++;
      $display("FAIL simul_rel_early got rel=%b lvl=%b exp 00000 01010", o_release, o_level);
    end
    step(1);
    checks++;
    if (o_release !== 5'b01010 || o_level !== 5'b00000 || o_any_press !== 1'b0) begin
      errors++;
      $display("FAIL simul_rel_edge got rel=%b lvl=%b any=%b exp 01010 00000 0",
               o_release, o_level, o_any_press);
    end
    step(4);
  endtask

  task automatic test_reset_mid();
    i_buttons = 5'b00001;
    step(3);
    rst_n = 1'b0;
    for (int j = 0; j < 3; j++) begin
      step(1);
      checks++;
      if ({o_level, o_press, o_release, o_any_press} !== 16'h0) begin
        errors++;
        $display("FAIL rstmid_hold j=%0d got lvl=%b prs=%b rel=%b any=%b exp all 0",
                 j, o_level, o_press, o_release, o_any_press);
      end
    end
    rst_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      step(1);
      checks++;
      if (o_press !== 5'b00000 || o_level !== 5'b00000) begin
        errors++;
        $display("FAIL rstmid_wait j=%0d got prs=%b lvl=%b exp 00000 00000",
                 j, o_press, o_level);
      end
    end
    step(1);
    checks++;
    if (o_press !== 5'b00001 || o_level !== 5'b00001 || o_any_press !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_press got prs=%b lvl=%b any=%b exp 00001 00001 1",
               o_press, o_level, o_any_press);
    end
    i_buttons = '0;
    step(8);
    checks++;
    if (o_level !== 5'b00000) begin
      errors++;
      $display("FAIL rstmid_settle got lvl=%b exp 00000", o_level);
    end
  endtask

  // Button 4 held; released so the debounced fall coincides with a due repeat pulse.
  task automatic test_auto_repeat();
    logic [3:0] exp_v;
    logic       exp_p;
    i_buttons = 5'b10000;
    step(6);
    checks++;
    if (o_press !== 5'b10000 || o_any_press !== 1'b1) begin
      errors++;
      $display("FAIL rpt_first got prs=%b any=%b exp 10000 1", o_press, o_any_press);
    end
    for (int i = 1; i <= 75; i++) begin
      if (i == 55) i_buttons = '0;
      step(1);
      exp_p = RPT_EN && (i == 20 || i == 28 || i == 36 || i == 44 || i == 52);
      exp_v = {(i < 60), exp_p, (i == 60), exp_p};
      checks++;
      if ({o_level[4], o_press[4], o_release[4], o_any_press} !== exp_v) begin
        errors++;
        $display("FAIL rpt_cycle i=%0d got lvl/prs/rel/any=%b exp %b", i,
                 {o_level[4], o_press[4], o_release[4], o_any_press}, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_auto_repeat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
